// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared state encoding, stage-bundle widths and NOP bundles
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Per-boundary bundle widths: pc, aluop, funct3/7, operands, imm, wd, wreg.
    localparam int IF_ID_W  = XLEN + XLEN;
    localparam int ID_EX_W  = XLEN + 4 + 3 + 7 + 3 * XLEN + REG_ADDR_W + 1;
    localparam int EX_MEM_W = XLEN + XLEN + REG_ADDR_W + 1;
    localparam int MEM_WB_W = XLEN + REG_ADDR_W + 1;

    localparam logic [XLEN-1:0]       NOP_INSTR     = 32'h0000_0013;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic                  WRITE_DISABLE = 1'b0;

    // Bubble encodings: wd = x0 and wreg = 0 in the low bits so a bubble never writes.
    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {{XLEN{1'b0}}, NOP_INSTR};
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = {{(ID_EX_W-REG_ADDR_W-1){1'b0}}, NOP_REG_ADDR, WRITE_DISABLE};
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {{(EX_MEM_W-REG_ADDR_W-1){1'b0}}, NOP_REG_ADDR, WRITE_DISABLE};
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = {{(MEM_WB_W-REG_ADDR_W-1){1'b0}}, NOP_REG_ADDR, WRITE_DISABLE};

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// rtl/pipe_stage_skid_sat_counter.sv - saturating event counter for perf debug
// Ports: clk; clr (sync clear, highest priority); inc (count this edge); count (CNT_W, stops at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid, flush and back-pressure counter
// Ports: clk, rst (sync, active-high); flush; in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream; bp_cnt counts stalled-output cycles.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bp_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    // Both handshake outputs decode registered state only, so ready never
    // depends combinationally on out_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_d  = in_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_valid && out_ready) begin
                    main_d = in_data;
                end else if (in_valid) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    main_d  = NOP_VALUE;
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    skid_d  = NOP_VALUE;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                main_d  = NOP_VALUE;
                skid_d  = NOP_VALUE;
                state_d = ST_EMPTY;
            end
        endcase
        // Flush drops everything, including a payload offered on this edge.
        if (flush) begin
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bp_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (out_valid & ~out_ready),
        .count (bp_cnt)
    );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, generalised pipeline stage register for any inter-stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Replaces the global stall-vector scheme with local valid/ready handshaking.
- Contains a 2-entry skid buffer, so an upstream stage never sees a combinational ready path.
- Adds synchronous flush, for branch mispredict, and a saturating back-pressure counter for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (the packed stage bundle: pc, aluop, funct3/7, operands, imm, wd, wreg).
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data whenever the stage holds no valid entry (bubble encoding).
- CNT_W, 16, width of the back-pressure counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- flush, in, 1, discard all held entries this edge.
- in_valid, in, 1, upstream presents a valid payload.
- in_ready, out, 1, stage can accept; registered, depends only on state.
- in_data, in, DATA_W, upstream payload.
- out_valid, out, 1, out_data is a valid entry.
- out_ready, in, 1, downstream accepts out_data this edge.
- out_data, out, DATA_W, payload to the next stage; registered.
- bp_cnt, out, CNT_W, saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main register (drives out_data) and skid register.
- States:
  - EMPTY: 0 entries.
  - BUSY: main valid.
  - FULL: main and skid valid.
- Derived outputs: in_ready = (state != FULL); out_valid = (state != EMPTY).
- Handshakes: a transfer occurs on an edge where valid and ready are both 1. The upstream may not retract in_valid once asserted until accepted; the bench checks this as an assertion.
- Transitions, evaluated at posedge when rst=0 and flush=0:
  - EMPTY, in_valid=1: main<=in_data; go to BUSY.
  - EMPTY, in_valid=0: stay EMPTY.
  - BUSY, in_valid=1, out_ready=1: main<=in_data; stay BUSY (full throughput, one entry per cycle).
  - BUSY, in_valid=1, out_ready=0: skid<=in_data; go to FULL.
  - BUSY, in_valid=0, out_ready=1: main<=NOP_VALUE; go to EMPTY.
  - BUSY, in_valid=0, out_ready=0: hold.
  - FULL, out_ready=1: main<=skid; skid<=NOP_VALUE; go to BUSY. in_ready is 0 in FULL, so in_valid is ignored.
  - FULL, out_ready=0: hold.
- Latency: 1 cycle from accepted input to out_valid when the stage is EMPTY or draining. Order is strictly FIFO; no entry is ever dropped or duplicated except by flush.
- Flush (flush=1, rst=0):
  - State goes to EMPTY; main<=NOP_VALUE; skid<=NOP_VALUE.
  - An in_data offered that same edge is discarded, even though in_ready was 1.
  - An out_ready handshake on that edge still counts as consumed downstream.
  - bp_cnt is unaffected.
- Reset (rst=1): priority over flush.
  - State EMPTY; main and skid = NOP_VALUE; out_valid=0; in_ready=1; out_data=NOP_VALUE; bp_cnt=0.
  - Reset mid-operation (BUSY or FULL) loses held entries identically to flush and also clears bp_cnt.
- bp_cnt:
  - Increments on every edge where out_valid=1 and out_ready=0.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst.
- Bubble rule: whenever out_valid=0, out_data equals NOP_VALUE exactly. This preserves the invariant that a non-valid stage writes no register (wreg=0 in the NOP encoding).
- Widths: payload passes through unmodified; no arithmetic on data.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2;
  - stage-bundle width constants per boundary (ID_EX_W etc.);
  - NOP bundle constants built from the existing NOP/NopRegAddr/WriteDisable defines.
- One sub-module is natural: sat_counter (CNT_W, inc, clr), used for bp_cnt and reusable for other perf counters.
- Everything else stays in pipe_stage_skid.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_data=0xA5 → out_valid=0, out_data=NOP_VALUE, in_ready=1, bp_cnt=0 after release.
- Streaming: out_ready=1 constant; send 0x1,0x2,0x3 on consecutive cycles → out_data=0x1,0x2,0x3 on the next three cycles with out_valid=1 throughout; in_ready never 0.
- Back-pressure to FULL: send 0x10 then 0x11 with out_ready=0 → state FULL, in_ready=0. Hold 5 cycles → bp_cnt=6 (counting from the 0x10 valid cycle). Raise out_ready → 0x10 then 0x11 emitted in order; no loss or duplicate.
- Flush while FULL: entries 0x20 and 0x21 held, flush=1 with in_valid=1 and in_data=0x22 → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1. 0x22 never appears.
- Saturation: CNT_W=4; hold out_valid=1 with out_ready=0 for 20 cycles → bp_cnt stops at 15.
- Random: constrained-random in_valid/out_ready/flush for 10k cycles against a FIFO scoreboard → order preserved, out_data==NOP_VALUE whenever out_valid=0, in_ready low only in FULL.
